// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path.
//   cam_state_e      : capture FSM state encoding
//   QQVGA_H/QQVGA_V  : default frame geometry (160x120)
//   rgb565_to_rgb332 : packs an RGB565 byte pair into one RGB332 byte
package cam_pkg;

  typedef enum logic [1:0] {
    S_WAIT_VS    = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_ACTIVE     = 2'd2
  } cam_state_e;

  localparam int unsigned QQVGA_H = 160;
  localparam int unsigned QQVGA_V = 120;

  // hi = RRRRRGGG, lo = GGGBBBBB. Keep R[4:2], G[5:3], B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture.sv
// Camera capture front end: collects RGB565 byte pairs from an OV-style sensor, converts each
// pixel to RGB332 and writes it to a downstream FIFO with its frame coordinates.
//   Pclk       : pixel clock, everything on the rising edge
//   rst        : synchronous active-low reset
//   vsync      : high during vertical blanking
//   href       : high while cam_data carries a valid byte
//   cam_data   : RGB565 byte stream, high byte first
//   fifo_full  : downstream FIFO full
//   pixel_data : RGB332 pixel (FIFO data_in)
//   pixel_wr   : one-cycle write strobe (FIFO wr)
//   pix_x/pix_y: coordinates of the pixel on pixel_data
//   frame_done : one-cycle pulse, registered, after vsync rises while capturing
//   overflow   : sticky, a pixel was lost to fifo_full; cleared at frame start
//   busy       : capture FSM in S_ACTIVE
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_PIXELS = QQVGA_H,
  parameter int unsigned V_LINES  = QQVGA_V,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7
) (
  input  logic           Pclk,
  input  logic           rst,
  input  logic           vsync,
  input  logic           href,
  input  logic [7:0]     cam_data,
  input  logic           fifo_full,
  output logic [7:0]     pixel_data,
  output logic           pixel_wr,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_done,
  output logic           overflow,
  output logic           busy
);

  // One spare bit so the counters can sit at the saturation value without wrapping.
  localparam int unsigned XCW = X_W + 1;
  localparam int unsigned YCW = Y_W + 1;
  localparam logic [XCW-1:0] XLim = XCW'(H_PIXELS);
  localparam logic [YCW-1:0] YLim = YCW'(V_LINES);

  cam_state_e     state_q, state_d;
  logic [XCW-1:0] x_q, x_d;
  logic [YCW-1:0] y_q, y_d;
  logic           phase_q, phase_d;
  logic [7:0]     hi_q, hi_d;
  logic           href_q, href_d;
  logic [7:0]     data_q, data_d;
  logic           wr_q, wr_d;
  logic [X_W-1:0] px_q, px_d;
  logic [Y_W-1:0] py_q, py_d;
  logic           fd_q, fd_d;
  logic           ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    href_d  = 1'b0;
    data_d  = data_q;
    wr_d    = 1'b0;
    px_d    = px_q;
    py_d    = py_q;
    fd_d    = 1'b0;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_WAIT_VS: begin
        if (vsync) state_d = S_WAIT_FRAME;
      end

      S_WAIT_FRAME: begin
        if (!vsync) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      S_ACTIVE: begin
        if (vsync) begin
          // Frame ends (possibly mid-line): drop any half-received pixel.
          state_d = S_WAIT_FRAME;
          fd_d    = 1'b1;
          phase_d = 1'b0;
        end else begin
          href_d = href;
          if (href) begin
            if (!phase_q) begin
              hi_d    = cam_data;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (x_q < XLim) begin
                x_d = x_q + 1'b1;
                if (y_q < YLim) begin
                  if (!fifo_full) begin
                    wr_d   = 1'b1;
                    data_d = rgb565_to_rgb332(hi_q, cam_data);
                    px_d   = x_q[X_W-1:0];
                    py_d   = y_q[Y_W-1:0];
                  end else begin
                    ovf_d = 1'b1;
                  end
                end
              end
            end
          end else if (href_q) begin
            // End of line: an odd trailing byte is discarded by clearing the phase.
            x_d     = '0;
            phase_d = 1'b0;
            if (y_q < YLim) y_d = y_q + 1'b1;
          end
        end
      end

      default: state_d = S_WAIT_VS;
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (!rst) begin
      state_q <= S_WAIT_VS;
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      href_q  <= 1'b0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      href_q  <= href_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pixel_data = data_q;
  assign pixel_wr   = wr_q;
  assign pix_x      = px_q;
  assign pix_y      = py_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with default 160x120 geometry.
module tb_cam_capture;

  logic       Pclk;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] cam_data;
  logic       fifo_full;
  logic [7:0] pixel_data;
  logic       pixel_wr;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       frame_done;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Written only by the monitor; tests compare deltas.
  int         wr_cnt = 0;
  int         fd_cnt = 0;
  logic [7:0] last_x = '0;
  logic [6:0] last_y = '0;

  cam_capture dut (
    .Pclk       (Pclk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .fifo_full  (fifo_full),
    .pixel_data (pixel_data),
    .pixel_wr   (pixel_wr),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  always @(negedge Pclk) begin
    if (pixel_wr) begin
      wr_cnt <= wr_cnt + 1;
      last_x <= pix_x;
      last_y <= pix_y;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  // Apply inputs, let one rising edge pass, return 1 ns after it.
  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d, input logic ff);
    vsync     = vs;
    href      = hr;
    cam_data  = d;
    fifo_full = ff;
    @(posedge Pclk);
    #1;
  endtask

  task automatic pix(input logic [7:0] hi, input logic [7:0] lo, input logic ff);
    cyc(1'b0, 1'b1, hi, ff);
    cyc(1'b0, 1'b1, lo, ff);
  endtask

  task automatic frame_start();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (pixel_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", pixel_data); end
    checks++; if (pixel_wr !== 1'b0) begin errors++; $display("FAIL rst_wr got %b want 0", pixel_wr); end
    checks++; if (pix_x !== 8'd0) begin errors++; $display("FAIL rst_x got %0d want 0", pix_x); end
    checks++; if (pix_y !== 7'd0) begin errors++; $display("FAIL rst_y got %0d want 0", pix_y); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b want 0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b1;
    // Bytes with vsync low before any vsync pulse must be ignored.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hF8, 1'b0);
    checks++; if (busy !== 1'b0 || wr_cnt !== 0) begin errors++; $display("FAIL rst_idle busy %b wr %0d want 0 0", busy, wr_cnt); end
  endtask

  task automatic test_basic();
    int b;
    frame_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    b = wr_cnt;
    cyc(1'b0, 1'b1, 8'hF8, 1'b0);
    checks++; if (pixel_wr !== 1'b0) begin errors++; $display("FAIL basic_hi_wr got %b want 0", pixel_wr); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (pixel_wr !== 1'b1 || pixel_data !== 8'hE0) begin errors++; $display("FAIL basic_p0 wr %b data %h want 1 e0", pixel_wr, pixel_data); end
    checks++; if (pix_x !== 8'd0 || pix_y !== 7'd0) begin errors++; $display("FAIL basic_p0_xy got %0d,%0d want 0,0", pix_x, pix_y); end
    cyc(1'b0, 1'b1, 8'h07, 1'b0);
    checks++; if (pixel_wr !== 1'b0) begin errors++; $display("FAIL basic_strobe got %b want 0", pixel_wr); end
    cyc(1'b0, 1'b1, 8'hE0, 1'b0);
    checks++; if (pixel_wr !== 1'b1 || pixel_data !== 8'h1C) begin errors++; $display("FAIL basic_p1 wr %b data %h want 1 1c", pixel_wr, pixel_data); end
    checks++; if (pix_x !== 8'd1 || pix_y !== 7'd0) begin errors++; $display("FAIL basic_p1_xy got %0d,%0d want 1,0", pix_x, pix_y); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (wr_cnt - b !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", wr_cnt - b); end
  endtask

  task automatic test_full_frame();
    int b;
    int fb;
    frame_start();
    b  = wr_cnt;
    fb = fd_cnt;
    for (int l = 0; l < 120; l++) begin
      for (int p = 0; p < 160; p++) pix(8'(l), 8'(p), 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
    end
    checks++; if (wr_cnt - b !== 19200) begin errors++; $display("FAIL full_count got %0d want 19200", wr_cnt - b); end
    checks++; if (last_x !== 8'd159 || last_y !== 7'd119) begin errors++; $display("FAIL full_last got %0d,%0d want 159,119", last_x, last_y); end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL full_fd got %b want 1", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf got %b want 0", overflow); end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL full_fd_pulse got %b want 0", frame_done); end
    checks++; if (fd_cnt - fb !== 1) begin errors++; $display("FAIL full_fd_count got %0d want 1", fd_cnt - fb); end
  endtask

  task automatic test_overflow();
    int b;
    frame_start();
    b = wr_cnt;
    pix(8'h00, 8'h00, 1'b0);
    pix(8'h00, 8'h00, 1'b0);
    pix(8'hFF, 8'hFF, 1'b1);
    checks++; if (pixel_wr !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop wr %b ovf %b want 0 1", pixel_wr, overflow); end
    pix(8'hE7, 8'h18, 1'b0);
    checks++; if (pixel_wr !== 1'b1 || pixel_data !== 8'hFF || pix_x !== 8'd3) begin errors++; $display("FAIL ovf_p3 wr %b data %h x %0d want 1 ff 3", pixel_wr, pixel_data, pix_x); end
    pix(8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (wr_cnt - b !== 4) begin errors++; $display("FAIL ovf_count got %0d want 4", wr_cnt - b); end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b1 || frame_done !== 1'b1) begin errors++; $display("FAIL ovf_sticky ovf %b fd %b want 1 1", overflow, frame_done); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_clear ovf %b busy %b want 0 1", overflow, busy); end
  endtask

  task automatic test_long_line();
    int b;
    frame_start();
    b = wr_cnt;
    for (int p = 0; p < 170; p++) pix(8'h55, 8'(p), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (wr_cnt - b !== 160) begin errors++; $display("FAIL long_count got %0d want 160", wr_cnt - b); end
    checks++; if (last_x !== 8'd159 || last_y !== 7'd0) begin errors++; $display("FAIL long_last got %0d,%0d want 159,0", last_x, last_y); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL long_ovf got %b want 0", overflow); end
    pix(8'h12, 8'h34, 1'b0);
    checks++; if (pixel_wr !== 1'b1 || pixel_data !== 8'h0A) begin errors++; $display("FAIL odd_p0 wr %b data %h want 1 0a", pixel_wr, pixel_data); end
    checks++; if (pix_x !== 8'd0 || pix_y !== 7'd1) begin errors++; $display("FAIL odd_xy got %0d,%0d want 0,1", pix_x, pix_y); end
    cyc(1'b0, 1'b1, 8'h56, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (pixel_wr !== 1'b0) begin errors++; $display("FAIL odd_drop got %b want 0", pixel_wr); end
    pix(8'hF8, 8'h00, 1'b0);
    checks++; if (pixel_data !== 8'hE0 || pix_x !== 8'd0 || pix_y !== 7'd2) begin errors++; $display("FAIL odd_next data %h xy %0d,%0d want e0 0,2", pixel_data, pix_x, pix_y); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (wr_cnt - b !== 162) begin errors++; $display("FAIL odd_count got %0d want 162", wr_cnt - b); end
  endtask

  task automatic test_vsync_abort();
    int b;
    frame_start();
    b = wr_cnt;
    pix(8'hF8, 8'h00, 1'b0);
    pix(8'h07, 8'hE0, 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 1'b1, 8'hBB, 1'b0);
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_fd fd %b busy %b want 1 0", frame_done, busy); end
    checks++; if (pixel_wr !== 1'b0 || wr_cnt - b !== 2) begin errors++; $display("FAIL abort_wr wr %b count %0d want 0 2", pixel_wr, wr_cnt - b); end
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
    checks++; if (wr_cnt - b !== 2 || frame_done !== 1'b0) begin errors++; $display("FAIL abort_hold count %0d fd %b want 2 0", wr_cnt - b, frame_done); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_resume got %b want 1", busy); end
    pix(8'h07, 8'hE0, 1'b0);
    checks++; if (pixel_data !== 8'h1C || pix_x !== 8'd0) begin errors++; $display("FAIL abort_fresh data %h x %0d want 1c 0", pixel_data, pix_x); end
  endtask

  task automatic test_reset_mid();
    int b;
    frame_start();
    pix(8'hF8, 8'h00, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_ovf got %b want 1", overflow); end
    cyc(1'b0, 1'b1, 8'h07, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'hE0, 1'b0);
    checks++; if (pixel_wr !== 1'b0 || pixel_data !== 8'h00) begin errors++; $display("FAIL rmid_out wr %b data %h want 0 00", pixel_wr, pixel_data); end
    checks++; if (overflow !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rmid_flags ovf %b busy %b fd %b want 0 0 0", overflow, busy, frame_done); end
    checks++; if (pix_x !== 8'd0 || pix_y !== 7'd0) begin errors++; $display("FAIL rmid_xy got %0d,%0d want 0,0", pix_x, pix_y); end
    rst = 1'b1;
    b = wr_cnt;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'hF8, 1'b0);
    checks++; if (wr_cnt - b !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle count %0d busy %b want 0 0", wr_cnt - b, busy); end
    frame_start();
    pix(8'hF8, 8'h00, 1'b0);
    checks++; if (pixel_wr !== 1'b1 || pixel_data !== 8'hE0) begin errors++; $display("FAIL rmid_resume wr %b data %h want 1 e0", pixel_wr, pixel_data); end
  endtask

  initial begin
    rst       = 1'b0;
    vsync     = 1'b0;
    href      = 1'b0;
    cam_data  = 8'h00;
    fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_full_frame();
    test_overflow();
    test_long_line();
    test_vsync_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
